// File: rtl/div_pkg.sv
// Shared encodings for the iterative restoring divider: controller state codes,
// Remainder register operation codes and the controller output bundle.
package div_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 6;

  // Controller states
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_ITER = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Remainder register operations
  localparam logic [2:0] REM_HOLD   = 3'd0;
  localparam logic [2:0] REM_LOAD   = 3'd1;
  localparam logic [2:0] REM_SLL    = 3'd2;
  localparam logic [2:0] REM_SLL_WR = 3'd3;
  localparam logic [2:0] REM_SRL_HI = 3'd4;

  typedef struct packed {
    logic       w_ctrl;
    logic [2:0] rem_ctrl;
    logic       q_bit;
    logic       alu_ctrl;
    logic       busy;
    logic       done;
    logic       dz_err;
  } ctrl_t;

  // Output decode; ITER is Mealy on the ALU sign so the quotient bit and
  // restore decision land in the same cycle as the subtraction.
  function automatic ctrl_t decode_ctrl(input logic [2:0] st,
                                        input logic       alu_neg,
                                        input logic       dz);
    ctrl_t c;
    c          = '0;
    c.rem_ctrl = REM_HOLD;
    case (st)
      ST_LOAD: begin
        c.w_ctrl   = 1'b1;
        c.rem_ctrl = REM_LOAD;
        c.busy     = 1'b1;
      end
      ST_ITER: begin
        c.alu_ctrl = 1'b1;
        c.busy     = 1'b1;
        c.q_bit    = ~alu_neg;
        c.rem_ctrl = alu_neg ? REM_SLL : REM_SLL_WR;
      end
      ST_FIX: begin
        c.rem_ctrl = REM_SRL_HI;
        c.busy     = 1'b1;
      end
      ST_DONE: begin
        c.done   = 1'b1;
        c.busy   = 1'b1;
        c.dz_err = dz;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter for the divider: counts enabled cycles up to LAST and then
// returns to zero so it never runs past the final iteration.
module div_iter_counter
  import div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int LAST  = DATA_W_DEF - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_V = CNT_W'(LAST);

  assign last = (count == LAST_V);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr || (en && last)) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/div_control.sv
// Sequencer for the 32-bit restoring divider: one quotient bit per clock, with
// a LOAD cycle before the iterations and a FIX cycle to undo the last shift.
module div_control
  import div_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             divisor_zero,
  input  logic             alu_neg,
  output logic             w_ctrl,
  output logic [2:0]       rem_ctrl,
  output logic             q_bit,
  output logic             alu_ctrl,
  output logic             busy,
  output logic             done,
  output logic             dz_err,
  output logic [2:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_count,
  output logic             dbg_dz
);

  // Handshake: start is a request sampled only at an edge while IDLE (never
  // queued); busy covers LOAD through DONE; done is a one-cycle pulse with
  // dz_err qualified by it. There is no back-pressure on done.

  logic [2:0]       state, state_nxt;
  logic             dz_q;
  logic [CNT_W-1:0] count;
  logic             cnt_last;
  logic             cnt_clr, cnt_en;
  ctrl_t            ctrl;

  assign cnt_en  = (state == ST_ITER);
  assign cnt_clr = (state != ST_ITER);

  div_iter_counter #(
    .CNT_W (CNT_W),
    .LAST  (DATA_W - 1)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (count),
    .last  (cnt_last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = dz_q ? ST_DONE : ST_ITER;
      ST_ITER: if (cnt_last) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Divide-by-zero flag is captured with the request and dropped on the way back to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dz_q <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      dz_q <= divisor_zero;
    end else if (state == ST_DONE) begin
      dz_q <= 1'b0;
    end
  end

  assign ctrl = decode_ctrl(state, alu_neg, dz_q);

  assign w_ctrl    = ctrl.w_ctrl;
  assign rem_ctrl  = ctrl.rem_ctrl;
  assign q_bit     = ctrl.q_bit;
  assign alu_ctrl  = ctrl.alu_ctrl;
  assign busy      = ctrl.busy;
  assign done      = ctrl.done;
  assign dz_err    = ctrl.dz_err;

  assign dbg_state = state;
  assign dbg_count = count;
  assign dbg_dz    = dz_q;

endmodule

// File: tb/tb_div_control.sv
// Bench for div_control: drives it against a behavioural Divisor/Remainder/ALU
// model and checks quotient, remainder, timing and handshake corner cases.
module tb_div_control;
  import div_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic        divisor_zero;
  logic        alu_neg;
  logic        w_ctrl;
  logic [2:0]  rem_ctrl;
  logic        q_bit;
  logic        alu_ctrl;
  logic        busy;
  logic        done;
  logic        dz_err;
  logic [2:0]  dbg_state;
  logic [5:0]  dbg_count;
  logic        dbg_dz;

  int errors = 0;
  int checks = 0;

  div_control dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .divisor_zero (divisor_zero),
    .alu_neg      (alu_neg),
    .w_ctrl       (w_ctrl),
    .rem_ctrl     (rem_ctrl),
    .q_bit        (q_bit),
    .alu_ctrl     (alu_ctrl),
    .busy         (busy),
    .done         (done),
    .dz_err       (dz_err),
    .dbg_state    (dbg_state),
    .dbg_count    (dbg_count),
    .dbg_dz       (dbg_dz)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // ---------------- behavioural datapath ----------------
  logic [31:0] dvd_in, div_in, divisor_r;
  logic [63:0] rem;
  logic [32:0] diff;

  assign divisor_zero = (div_in == 32'd0);
  assign diff    = alu_ctrl ? ({1'b0, rem[63:32]} - {1'b0, divisor_r}) : {1'b0, rem[63:32]};
  assign alu_neg = diff[32];

  always @(posedge clk) begin
    if (w_ctrl) divisor_r <= div_in;
    case (rem_ctrl)
      REM_LOAD:   rem <= {31'd0, dvd_in, 1'b0};
      REM_SLL:    rem <= {rem[62:0], q_bit};
      REM_SLL_WR: rem <= {diff[30:0], rem[31:0], q_bit};
      REM_SRL_HI: rem <= {1'b0, rem[63:33], rem[31:0]};
      default: ;
    endcase
  end

  // ---------------- scoreboard helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[8];

  // ---------------- driver / monitor task ----------------
  // Issues one start pulse and watches 41 cycles. k counts edges after the
  // accept edge E. glitch_k >= 0 re-pulses start (with a zero divisor) there.
  task automatic run_op(input vec_t v, input string tag, input int glitch_k);
    int          w_n, it_n, alu_n, busy_n, done_n, done_k;
    logic [31:0] qpat, q_cap, r_cap;
    logic        dz_cap;
    int          exp_lat;
    w_n = 0; it_n = 0; alu_n = 0; busy_n = 0; done_n = 0; done_k = -1;
    qpat = '0; q_cap = '0; r_cap = '0; dz_cap = 1'b0;
    exp_lat = v.dz ? 1 : 34;
    @(negedge clk);
    dvd_in = v.dvd;
    div_in = v.dvs;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (k == glitch_k) begin
        start  = 1'b1;
        div_in = 32'd0;
      end else if (glitch_k >= 0 && k == glitch_k + 1) begin
        start = 1'b0;
      end
      if (w_ctrl)   w_n++;
      if (alu_ctrl) alu_n++;
      if (busy)     busy_n++;
      if (rem_ctrl == REM_SLL || rem_ctrl == REM_SLL_WR) begin
        it_n++;
        qpat = {qpat[30:0], q_bit};
      end
      if (done) begin
        done_n++;
        if (done_k < 0) begin
          done_k = k;
          dz_cap = dz_err;
          q_cap  = rem[31:0];
          r_cap  = rem[63:32];
        end
      end
      @(negedge clk);
    end
    check({tag, " done_count"}, 64'(done_n), 64'd1);
    check({tag, " done_latency"}, 64'(done_k), 64'(exp_lat));
    check({tag, " w_ctrl_cycles"}, 64'(w_n), 64'd1);
    check({tag, " iter_cycles"}, 64'(it_n), v.dz ? 64'd0 : 64'd32);
    check({tag, " alu_sub_cycles"}, 64'(alu_n), v.dz ? 64'd0 : 64'd32);
    check({tag, " busy_cycles"}, 64'(busy_n), 64'(exp_lat + 1));
    check({tag, " dz_err"}, 64'(dz_cap), 64'(v.dz));
    if (!v.dz) begin
      check({tag, " quotient"}, 64'(q_cap), 64'(v.q));
      check({tag, " remainder"}, 64'(r_cap), 64'(v.r));
      check({tag, " q_bit_pattern"}, 64'(qpat), 64'(v.q));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          done_n, w_first2, done1_k, done2_k;
    logic [31:0] q2;
    logic [8:0]  outs;

    vecs[0] = '{dvd: 32'd100,        dvs: 32'd7,          q: 32'd14,         r: 32'd2,          dz: 1'b0};
    vecs[1] = '{dvd: 32'hFFFF_FFFF,  dvs: 32'hFF00_F0F0,  q: 32'd1,          r: 32'h00FF_0F0F,  dz: 1'b0};
    vecs[2] = '{dvd: 32'd5,          dvs: 32'd0,          q: 32'd0,          r: 32'd0,          dz: 1'b1};
    vecs[3] = '{dvd: 32'd1000,       dvs: 32'd10,         q: 32'd100,        r: 32'd0,          dz: 1'b0};
    vecs[4] = '{dvd: 32'd7,          dvs: 32'd100,        q: 32'd0,          r: 32'd7,          dz: 1'b0};
    vecs[5] = '{dvd: 32'h1234_5678,  dvs: 32'h0000_1234,  q: 32'h0001_0004,  r: 32'h0000_0DA8,  dz: 1'b0};
    vecs[6] = '{dvd: 32'hFFFF_FFFF,  dvs: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0,          dz: 1'b0};
    vecs[7] = '{dvd: 32'hFFFF_FFFF,  dvs: 32'h8000_0000,  q: 32'd1,          r: 32'h7FFF_FFFF,  dz: 1'b0};

    reset  = 1'b0;
    start  = 1'b0;
    dvd_in = '0;
    div_in = 32'd1;

    // Reset state
    #1;
    outs = {w_ctrl, rem_ctrl, q_bit, alu_ctrl, busy, done, dz_err};
    check("reset outputs", 64'(outs), 64'd0);
    check("reset state", 64'(dbg_state), 64'(ST_IDLE));
    check("reset count", 64'(dbg_count), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    done_n = 0;
    outs   = '0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done) done_n++;
      outs = outs | {w_ctrl, rem_ctrl, q_bit, alu_ctrl, busy, done, dz_err};
    end
    check("idle no_done", 64'(done_n), 64'd0);
    check("idle outputs", 64'(outs), 64'd0);
    check("idle state", 64'(dbg_state), 64'(ST_IDLE));

    // Table-driven operations
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i), -1);
    end

    // start re-pulsed at ITER count=10 (k=11) must be ignored
    run_op(vecs[0], "ignore_start", 11);
    run_op(vecs[3], "after_ignore", -1);

    // start held high: re-accepted only at the first IDLE edge
    @(negedge clk);
    dvd_in = 32'd100;
    div_in = 32'd7;
    start  = 1'b1;
    @(negedge clk);
    w_first2 = -1; done1_k = -1; done2_k = -1; q2 = '0;
    for (int k = 0; k <= 75; k++) begin
      if (k == 71) start = 1'b0;
      if (w_ctrl && k > 0 && w_first2 < 0) w_first2 = k;
      if (done && done1_k < 0) begin
        done1_k = k;
      end else if (done && done2_k < 0) begin
        done2_k = k;
        q2 = rem[31:0];
      end
      @(negedge clk);
    end
    check("held_start reaccept", 64'(w_first2), 64'd36);
    check("held_start done1", 64'(done1_k), 64'd34);
    check("held_start done2", 64'(done2_k), 64'd70);
    check("held_start quotient2", 64'(q2), 64'd14);
    check("held_start idle_after", 64'(busy), 64'd0);

    // Reset asserted in ITER at count=16
    @(negedge clk);
    dvd_in = 32'd100;
    div_in = 32'd7;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    check("pre_reset count", 64'(dbg_count), 64'd16);
    check("pre_reset state", 64'(dbg_state), 64'(ST_ITER));
    reset = 1'b0;
    #1;
    outs = {w_ctrl, rem_ctrl, q_bit, alu_ctrl, busy, done, dz_err};
    check("mid_reset outputs", 64'(outs), 64'd0);
    check("mid_reset state", 64'(dbg_state), 64'(ST_IDLE));
    check("mid_reset count", 64'(dbg_count), 64'd0);
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    done_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    check("mid_reset no_done", 64'(done_n), 64'd0);
    run_op(vecs[0], "post_reset", -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
